// File: rtl/dense2_argmax.sv
// dense2_argmax: serial argmax over a captured vector of signed class scores.
// One lane is compared per enabled cycle; the winner is emitted as a one-cycle strobe.
module dense2_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ena,
    input  logic                              in_valid,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] dense_sum2_in,
    output logic                              busy,
    output logic                              out_valid,
    output logic [IDX_WIDTH-1:0]              class_idx,
    output logic [DATA_WIDTH-1:0]             max_score,
    output logic [CNT_WIDTH-1:0]              frame_cnt,
    output logic                              drop_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;
    localparam int VW = NUM_CLASSES * DATA_WIDTH;

    logic [0:0]            state_q, state_d;
    logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;
    logic [IDX_WIDTH-1:0]  class_idx_q, class_idx_d;
    logic [DATA_WIDTH-1:0] best_q, best_d;
    logic [DATA_WIDTH-1:0] max_score_q, max_score_d;
    logic [VW-1:0]         vec_q, vec_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
    logic                  drop_err_q, drop_err_d;

    logic [DATA_WIDTH-1:0] lanes [NUM_CLASSES];
    logic [DATA_WIDTH-1:0] lane;
    logic                  gt;
    logic                  is_last;
    logic [DATA_WIDTH-1:0] cand_best;
    logic [IDX_WIDTH-1:0]  cand_idx;

    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_lane
        assign lanes[i] = vec_q[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Strict greater-than keeps the lowest index on ties.
    assign lane      = lanes[ptr_q];
    assign gt        = $signed(lane) > $signed(best_q);
    assign is_last   = ptr_q == IDX_WIDTH'(NUM_CLASSES - 1);
    assign cand_best = gt ? lane : best_q;
    assign cand_idx  = gt ? ptr_q : best_idx_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        vec_d       = vec_q;
        out_valid_d = 1'b0;
        class_idx_d = class_idx_q;
        max_score_d = max_score_q;
        frame_cnt_d = frame_cnt_q;
        drop_err_d  = drop_err_q;
        if (ena && state_q == IDLE && in_valid) begin
            state_d    = SCAN;
            vec_d      = dense_sum2_in;
            best_d     = dense_sum2_in[DATA_WIDTH-1:0];
            best_idx_d = '0;
            ptr_d      = IDX_WIDTH'(1);
        end else if (ena && state_q == SCAN) begin
            drop_err_d = drop_err_q | in_valid;
            best_d     = cand_best;
            best_idx_d = cand_idx;
            ptr_d      = ptr_q + IDX_WIDTH'(1);
            state_d    = is_last ? IDLE : SCAN;
            out_valid_d = is_last;
            class_idx_d = is_last ? cand_idx : class_idx_q;
            max_score_d = is_last ? cand_best : max_score_q;
            frame_cnt_d = is_last ? frame_cnt_q + CNT_WIDTH'(1) : frame_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            vec_q       <= '0;
            out_valid_q <= 1'b0;
            class_idx_q <= '0;
            max_score_q <= '0;
            frame_cnt_q <= '0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            vec_q       <= vec_d;
            out_valid_q <= out_valid_d;
            class_idx_q <= class_idx_d;
            max_score_q <= max_score_d;
            frame_cnt_q <= frame_cnt_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign busy      = state_q == SCAN;
    assign out_valid = out_valid_q;
    assign class_idx = class_idx_q;
    assign max_score = max_score_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_err  = drop_err_q;
endmodule

// File: tb/tb_dense2_argmax.sv
// tb_dense2_argmax: scoreboard bench; expected results are queued at send time
// and matched against every out_valid strobe by a monitor.
module tb_dense2_argmax;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b1;
    logic         in_valid = 1'b0;
    logic [159:0] dense_sum2_in = '0;
    logic         busy, out_valid, drop_err;
    logic [3:0]   class_idx;
    logic [15:0]  max_score, frame_cnt;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] score;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] model_cnt = '0;
    logic        prev_ov = 1'b0;

    localparam logic [159:0] VEC_A = 160'hfd41_ff89_fd84_00c4_01cc_0446_0116_fd11_0012_00a8;

    dense2_argmax dut (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .dense_sum2_in(dense_sum2_in),
        .busy(busy), .out_valid(out_valid), .class_idx(class_idx), .max_score(max_score),
        .frame_cnt(frame_cnt), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) begin
            vectors++;
            if (prev_ov) begin
                miscompares++;
                $display("FAIL out_valid_width: high on two consecutive cycles");
            end
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_result: got idx %0d score %h, none expected", class_idx, max_score);
            end else begin
                e = sb.pop_front();
                if (class_idx !== e.idx || max_score !== e.score || frame_cnt !== e.cnt) begin
                    miscompares++;
                    $display("FAIL result: got idx %0d score %h cnt %h, expected idx %0d score %h cnt %h",
                             class_idx, max_score, frame_cnt, e.idx, e.score, e.cnt);
                end
            end
        end
        prev_ov = out_valid;
    end

    function automatic logic [19:0] ref_max(input logic [159:0] v);
        logic signed [15:0] b = v[15:0];
        logic [3:0] bi = '0;
        for (int i = 1; i < 10; i++) begin
            if ($signed(v[i*16 +: 16]) > b) begin
                b  = v[i*16 +: 16];
                bi = 4'(i);
            end
        end
        return {bi, b};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        model_cnt = '0;
    endtask

    task automatic send(input logic [159:0] v, input logic [3:0] ei, input logic [15:0] es, input bit push);
        dense_sum2_in = v;
        in_valid = 1'b1;
        if (push) begin
            model_cnt = model_cnt + 16'd1;
            sb.push_back('{ei, es, model_cnt});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        if (!out_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: no out_valid within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({busy, out_valid, class_idx, max_score, frame_cnt, drop_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got %b/%b/%h/%h/%h/%b, expected all zero",
                     busy, out_valid, class_idx, max_score, frame_cnt, drop_err);
        end
    endtask

    task automatic test_basic();
        int n;
        send(VEC_A, 4'd4, 16'h0446, 1'b1);
        dense_sum2_in = {10{16'h7fff}};
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_scan: got %b, expected 1", busy);
        end
        wait_out(n);
        vectors++;
        if (n !== 9) begin
            miscompares++;
            $display("FAIL latency: got %0d, expected 9", n);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || class_idx !== 4'd4 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL hold: got ov %b idx %0d busy %b, expected 0 4 0", out_valid, class_idx, busy);
        end
    endtask

    task automatic test_patterns();
        int n;
        logic [159:0] v;
        v = {10{16'hfd00}};
        v[7*16 +: 16] = 16'hff00;
        send(v, 4'd7, 16'hff00, 1'b1);
        wait_out(n);
        v = {10{16'h8000}};
        v[9*16 +: 16] = 16'h7fff;
        send(v, 4'd9, 16'h7fff, 1'b1);
        wait_out(n);
        vectors++;
        if (n !== 9) begin
            miscompares++;
            $display("FAIL latency_patterns: got %0d, expected 9", n);
        end
    endtask

    task automatic test_ties();
        int n;
        logic [159:0] v;
        v = '0;
        v[2*16 +: 16] = 16'h0100;
        v[8*16 +: 16] = 16'h0100;
        send(v, 4'd2, 16'h0100, 1'b1);
        wait_out(n);
        send({10{16'h8000}}, 4'd0, 16'h8000, 1'b1);
        wait_out(n);
    endtask

    task automatic test_overlap();
        int n;
        do_reset();
        send(VEC_A, 4'd4, 16'h0446, 1'b1);
        repeat (2) @(negedge clk);
        dense_sum2_in = {10{16'h7fff}};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (drop_err !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_err_set: got %b, expected 1", drop_err);
        end
        wait_out(n);
        vectors++;
        if (n !== 6) begin
            miscompares++;
            $display("FAIL overlap_latency: got %0d, expected 6", n);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [159:0] v;
        logic [19:0] r;
        do_reset();
        send(VEC_A, 4'd4, 16'h0446, 1'b1);
        wait_out(n);
        v = 160'h0001_0002_0003_7ffe_0005_0006_0007_0008_0009_000a;
        r = ref_max(v);
        send(v, r[19:16], r[15:0], 1'b1);
        wait_out(n);
        vectors++;
        if (n !== 9 || drop_err !== 1'b0 || frame_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL back_to_back: got lat %0d drop %b cnt %0d, expected 9 0 2", n, drop_err, frame_cnt);
        end
    endtask

    task automatic test_stall();
        int n;
        logic [159:0] v;
        logic [19:0] r;
        v = 160'h0010_fff0_0020_ffe0_0030_0500_0040_ffc0_0050_0060;
        r = ref_max(v);
        send(v, r[19:16], r[15:0], 1'b1);
        repeat (2) @(negedge clk);
        ena = 1'b0;
        dense_sum2_in = {10{16'h7fff}};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold: got busy %b ov %b, expected 1 0", busy, out_valid);
        end
        ena = 1'b1;
        wait_out(n);
        vectors++;
        if (2 + 4 + n !== 13 || drop_err !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_latency: got lat %0d drop %b, expected 13 0", 6 + n, drop_err);
        end
        ena = 1'b0;
        send(VEC_A, 4'd0, 16'h0, 1'b0);
        ena = 1'b1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_capture_when_stalled: got busy %b, expected 0", busy);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        send(VEC_A, 4'd0, 16'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, out_valid, class_idx, max_score, frame_cnt, drop_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_scan: got %b/%b/%h/%h/%h/%b, expected all zero",
                     busy, out_valid, class_idx, max_score, frame_cnt, drop_err);
        end
        rst = 1'b0;
        sb.delete();
        model_cnt = '0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_wrap();
        int n;
        force dut.frame_cnt_q = 16'hffff;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        vectors++;
        if (frame_cnt !== 16'hffff) begin
            miscompares++;
            $display("FAIL cnt_preset: got %h, expected ffff", frame_cnt);
        end
        model_cnt = 16'hffff;
        send(VEC_A, 4'd4, 16'h0446, 1'b1);
        wait_out(n);
        vectors++;
        if (frame_cnt !== 16'h0000) begin
            miscompares++;
            $display("FAIL cnt_wrap: got %h, expected 0000", frame_cnt);
        end
    endtask

    task automatic test_random();
        int n;
        logic [159:0] v;
        logic [19:0] r;
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 10; j++) v[j*16 +: 16] = 16'($urandom);
            if (k == 0) v[5*16 +: 16] = v[3*16 +: 16];
            r = ref_max(v);
            send(v, r[19:16], r[15:0], 1'b1);
            wait_out(n);
            vectors++;
            if (n !== 9) begin
                miscompares++;
                $display("FAIL random_latency: got %0d, expected 9", n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_ties();
        test_overlap();
        test_back_to_back();
        test_stall();
        test_reset_mid_scan();
        test_wrap();
        test_random();
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
